// File: rtl/sram_access_controller_if.sv
// Request/response bus between the cache controller (master) and the SRAM access controller (slave).
interface sram_access_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [63:0] read_data;
    logic        ready;

    modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
    modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_access_controller.sv
// Sequences one word write or one 64-bit line read onto a 256K x 16 asynchronous SRAM.
// Optional SRAM_LINE_BUF_EN: one-entry line buffer that serves repeated reads of the last line read.
module sram_access_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SLOT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    sram_access_controller_if.slave  bus,
    inout  wire  [15:0]              SRAM_DQ,
    output logic [17:0]              SRAM_ADDR,
    output logic                     SRAM_UB_N,
    output logic                     SRAM_LB_N,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_OE_N
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_CYC = 4'(SLOT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              op_wr_q, op_wr_d;
    logic [17:0]       base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        slot_q, slot_d;
    logic [3:0]        cyc_q, cyc_d;
    logic [3:0][15:0]  hw_q, hw_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic [17:0]       addr_q, addr_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [15:0]       dq_out_q, dq_out_d;

    logic [31:0]       off;
    logic              req_wr, req_rd, slot_end, last_slot;
    logic              hit;
    logic [63:0]       hit_data;
    wire               unused_off = ^{off[31:19], off[1:0]};

`ifdef SRAM_LINE_BUF_EN
    logic [63:0]       lbuf_q, lbuf_d;
    logic [15:0]       ltag_q, ltag_d;
    logic              lvld_q, lvld_d;
`endif

    always_comb begin
        off       = bus.address - BASE_ADDR;
        req_wr    = bus.wr_en & ~bus.rd_en;
        req_rd    = bus.rd_en & ~bus.wr_en;
        slot_end  = (cyc_q == LAST_CYC);
        last_slot = op_wr_q ? (slot_q == 2'd1) : (slot_q == 2'd3);
`ifdef SRAM_LINE_BUF_EN
        hit       = req_rd && lvld_q && (ltag_q == off[18:3]);
        hit_data  = lbuf_q;
`else
        hit       = 1'b0;
        hit_data  = '0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        op_wr_d  = op_wr_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        slot_d   = slot_q;
        cyc_d    = cyc_q;
        hw_d     = hw_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        addr_d   = addr_q;
        we_n_d   = we_n_q;
        oe_n_d   = oe_n_q;
        dq_oe_d  = dq_oe_q;
        dq_out_d = dq_out_q;
`ifdef SRAM_LINE_BUF_EN
        lbuf_d   = lbuf_q;
        ltag_d   = ltag_q;
        lvld_d   = lvld_q;
`endif
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    rdata_d = hit_data;
                end else if (req_wr || req_rd) begin
                    // Outputs are registered, so slot 0 cycle 0 is set up here.
                    state_d  = ACCESS;
                    op_wr_d  = req_wr;
                    wdata_d  = bus.write_data;
                    base_d   = req_wr ? {off[18:2], 1'b0} : {off[18:3], 2'b00};
                    slot_d   = 2'd0;
                    cyc_d    = 4'd0;
                    addr_d   = base_d;
                    we_n_d   = ~req_wr;
                    oe_n_d   = req_wr;
                    dq_oe_d  = req_wr;
                    dq_out_d = bus.write_data[15:0];
`ifdef SRAM_LINE_BUF_EN
                    if (req_wr && (ltag_q == off[18:3]))
                        lvld_d = 1'b0;
`endif
                end
            end
            ACCESS: begin
                if (!op_wr_q && slot_end)
                    hw_d[slot_q] = SRAM_DQ;
                if (slot_end) begin
                    cyc_d = 4'd0;
                    if (last_slot) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        we_n_d  = 1'b1;
                        oe_n_d  = 1'b0;
                        dq_oe_d = 1'b0;
                        if (!op_wr_q) begin
                            rdata_d = {SRAM_DQ, hw_q[2], hw_q[1], hw_q[0]};
`ifdef SRAM_LINE_BUF_EN
                            lbuf_d  = rdata_d;
                            ltag_d  = base_q[17:2];
                            lvld_d  = 1'b1;
`endif
                        end
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
                // WE_N rises on the last cycle of each write slot so addr/data hold across the edge.
                if (state_d == ACCESS) begin
                    addr_d   = base_q + {16'b0, slot_d};
                    we_n_d   = ~(op_wr_q && (cyc_d != LAST_CYC));
                    oe_n_d   = op_wr_q;
                    dq_oe_d  = op_wr_q;
                    dq_out_d = slot_d[0] ? wdata_q[31:16] : wdata_q[15:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= 2'd0;
            cyc_q   <= 4'd0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b0;
            dq_oe_q <= 1'b0;
`ifdef SRAM_LINE_BUF_EN
            lvld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cyc_q   <= cyc_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            dq_oe_q <= dq_oe_d;
`ifdef SRAM_LINE_BUF_EN
            lvld_q  <= lvld_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        op_wr_q  <= op_wr_d;
        base_q   <= base_d;
        wdata_q  <= wdata_d;
        hw_q     <= hw_d;
        dq_out_q <= dq_out_d;
`ifdef SRAM_LINE_BUF_EN
        lbuf_q   <= lbuf_d;
        ltag_q   <= ltag_d;
`endif
    end

    assign SRAM_DQ       = dq_oe_q ? dq_out_q : 16'bz;
    assign SRAM_ADDR     = addr_q;
    assign SRAM_WE_N     = we_n_q;
    assign SRAM_OE_N     = oe_n_q;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;
    assign SRAM_CE_N     = 1'b0;
    assign bus.ready     = ready_q;
    assign bus.read_data = rdata_q;
endmodule

// File: tb/tb_sram_access_controller.sv
// Directed bench for sram_access_controller with a behavioural 16-bit SRAM on the pins.
module tb_sram_access_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_access_controller_if bus();
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, ce_n, we_n, oe_n;

    sram_access_controller dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .SRAM_CE_N (ce_n),
        .SRAM_WE_N (we_n),
        .SRAM_OE_N (oe_n)
    );

    logic [15:0] mem [0:63];
    assign sram_dq = oe_n ? 16'bz : mem[sram_addr[5:0]];
    always @(posedge clk) if (!we_n) mem[sram_addr[5:0]] <= sram_dq;

`ifdef SRAM_LINE_BUF_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 9;
`endif

    int checks = 0;
    int errors = 0;
    logic [17:0] tr_addr [0:40];
    logic        tr_we   [0:40];
    logic        tr_oe   [0:40];
    logic        tr_rdy  [0:40];
    logic [15:0] tr_dq   [0:40];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request in an IDLE cycle; lat is the cycle ready was seen (-1 on timeout).
    task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input bit drop_early, output int lat);
        bus.wr_en      = wr;
        bus.rd_en      = !wr;
        bus.address    = addr;
        bus.write_data = data;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (drop_early && n == 2) begin
                bus.wr_en = 1'b0;
                bus.rd_en = 1'b0;
            end
            tr_addr[n] = sram_addr;
            tr_we[n]   = we_n;
            tr_oe[n]   = oe_n;
            tr_rdy[n]  = bus.ready;
            tr_dq[n]   = sram_dq;
            if (bus.ready) begin
                lat = n;
                break;
            end
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        tick;
    endtask

    int          lat;
    logic [17:0] a0;
    logic [17:0] exp_wa [1:4];
    logic        exp_we [1:4];
    logic [17:0] exp_ra [1:8];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
        exp_wa = '{18'd0, 18'd0, 18'd1, 18'd1};
        exp_we = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_ra = '{18'd0, 18'd0, 18'd1, 18'd1, 18'd2, 18'd2, 18'd3, 18'd3};

        // Reset
        rst = 1'b1;
        tick; tick;
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_rdata", bus.read_data, 64'd0);
        check("rst_we_n", 64'(we_n), 64'd1);
        check("rst_oe_n", 64'(oe_n), 64'd0);
        check("rst_addr", 64'(sram_addr), 64'd0);
        check("tie_n", 64'({ub_n, lb_n, ce_n}), 64'd0);
        rst = 1'b0;
        tick;

        // Word write: two slots, WE_N low on the first cycle of each
        do_op(1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, lat);
        check("wr_lat", 64'(lat), 64'd5);
        for (int n = 1; n <= 4; n++) begin
            check($sformatf("wr_addr%0d", n), 64'(tr_addr[n]), 64'(exp_wa[n]));
            check($sformatf("wr_we%0d", n), 64'(tr_we[n]), 64'(exp_we[n]));
            check($sformatf("wr_oe%0d", n), 64'(tr_oe[n]), 64'd1);
            check($sformatf("wr_rdy%0d", n), 64'(tr_rdy[n]), 64'd0);
        end
        check("wr_dq1", 64'(tr_dq[1]), 64'hBEEF);
        check("wr_dq3", 64'(tr_dq[3]), 64'hDEAD);
        check("wr_oe_done", 64'(tr_oe[5]), 64'd0);
        check("mem0", 64'(mem[0]), 64'hBEEF);
        check("mem1", 64'(mem[1]), 64'hDEAD);

        // Two writes then a line read (request dropped mid-access)
        do_op(1'b1, 32'd1024, 32'h11111111, 1'b0, lat);
        check("wr1_lat", 64'(lat), 64'd5);
        do_op(1'b1, 32'd1028, 32'h22222222, 1'b0, lat);
        check("wr2_lat", 64'(lat), 64'd5);
        do_op(1'b0, 32'd1028, 32'h0, 1'b1, lat);
        check("rd_lat", 64'(lat), 64'd9);
        for (int n = 1; n <= 8; n++) begin
            check($sformatf("rd_addr%0d", n), 64'(tr_addr[n]), 64'(exp_ra[n]));
            check($sformatf("rd_we%0d", n), 64'(tr_we[n]), 64'd1);
            check($sformatf("rd_oe%0d", n), 64'(tr_oe[n]), 64'd0);
        end
        check("rd_data", bus.read_data, 64'h2222222211111111);

        // Both requests high: nothing happens
        a0 = sram_addr;
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.address = 32'd1032;
        for (int n = 0; n < 10; n++) begin
            tick;
            check("both_we", 64'(we_n), 64'd1);
            check("both_rdy", 64'(bus.ready), 64'd0);
            check("both_addr", 64'(sram_addr), 64'(a0));
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        tick;

        // Reset during the second cycle of a write access
        bus.wr_en = 1'b1; bus.address = 32'd1032; bus.write_data = 32'hCAFEF00D;
        tick;
        tick;
        rst = 1'b1; bus.wr_en = 1'b0;
        tick;
        check("abort_we", 64'(we_n), 64'd1);
        check("abort_oe", 64'(oe_n), 64'd0);
        check("abort_rdy", 64'(bus.ready), 64'd0);
        check("abort_addr", 64'(sram_addr), 64'd0);
        check("abort_rdata", bus.read_data, 64'd0);
        rst = 1'b0;
        tick;
        check("abort_no_rdy", 64'(bus.ready), 64'd0);
        do_op(1'b0, 32'd1024, 32'h0, 1'b0, lat);
        check("post_rst_lat", 64'(lat), 64'd9);
        check("post_rst_data", bus.read_data, 64'h2222222211111111);

        // Repeated read (buffer hit when the line buffer is built in), then invalidating write
        a0 = sram_addr;
        do_op(1'b0, 32'd1024, 32'h0, 1'b0, lat);
        check("rerd_lat", 64'(lat), 64'(HIT_LAT));
        check("rerd_data", bus.read_data, 64'h2222222211111111);
`ifdef SRAM_LINE_BUF_EN
        check("hit_addr", 64'(tr_addr[1]), 64'(a0));
        check("hit_we", 64'(tr_we[1]), 64'd1);
`endif
        do_op(1'b1, 32'd1028, 32'h33333333, 1'b0, lat);
        check("wr3_lat", 64'(lat), 64'd5);
        do_op(1'b0, 32'd1024, 32'h0, 1'b0, lat);
        check("inval_lat", 64'(lat), 64'd9);
        check("inval_data", bus.read_data, 64'h3333333311111111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
